wb_machine_timer: RTL and testbench

- Wishbone responder peripheral on the core's split read/write memory-mapped register bus, sitting beside the existing peripherals block.
- Provides a RISC-V style 64-bit mtime counter with a programmable prescaler and a 64-bit mtimecmp comparator.
- Drives a level timer interrupt back toward the core.

---
 rtl/wb_machine_timer_pkg.sv | 33 +++
 rtl/wb_machine_timer_prescaler.sv | 34 +++
 rtl/wb_machine_timer.sv | 163 ++++++++++++++++
 tb/tb_wb_machine_timer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_machine_timer_pkg.sv
// Shared constants for the Wishbone machine timer: bus widths, register
// offsets, CTRL field positions and the byte-lane merge helper.
package wb_machine_timer_pkg;

  localparam int XLEN             = 32;
  localparam int XLEN_BYTES       = XLEN / 8;
  localparam int MM_REG_ADDR_BITS = 8;
  localparam int PRESCALE_W       = 16;

  localparam int unsigned DEFAULT_BASE_ADDR = 0;

  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;
  localparam logic [2:0] OFF_STATUS      = 3'd5;

  localparam int CTRL_RUN_BIT    = 31;
  localparam int CTRL_IRQ_EN_BIT = 30;

  function automatic logic [XLEN-1:0] apply_sel(input logic [XLEN-1:0] old_val,
                                                input logic [XLEN-1:0] new_val,
                                                input logic [XLEN_BYTES-1:0] sel);
    logic [XLEN-1:0] r;
    r = old_val;
    for (int b = 0; b < XLEN_BYTES; b++) begin
      if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_machine_timer_prescaler.sv
// Reload down-counter: emits a one-cycle tick every prescale+1 cycles while
// run is high, and freezes while run is low.
module timer_prescaler
  import wb_machine_timer_pkg::*;
#(
  parameter logic [PRESCALE_W-1:0] PRESCALE_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sync_reset,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] load_val,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = run && (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= PRESCALE_RESET;
    end else if (sync_reset) begin
      cnt <= PRESCALE_RESET;
    end else if (load) begin
      cnt <= load_val;
    end else if (run) begin
      cnt <= (cnt == '0) ? prescale : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/wb_machine_timer.sv
// Wishbone machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp,
// atomic hi/lo read via a shadow, and a registered level timer interrupt.
module wb_machine_timer
  import wb_machine_timer_pkg::*;
#(
  parameter int unsigned              BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter logic [PRESCALE_W-1:0]    PRESCALE_RESET = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sync_reset,
  input  logic                        WB_RD_STB_I,
  input  logic [MM_REG_ADDR_BITS-1:0] WB_RD_ADR_I,
  output logic [XLEN-1:0]             WB_RD_DAT_O,
  output logic                        WB_RD_ACK_O,
  input  logic                        WB_WR_STB_I,
  input  logic                        WB_WR_WE_I,
  input  logic [XLEN_BYTES-1:0]       WB_WR_SEL_I,
  input  logic [MM_REG_ADDR_BITS-1:0] WB_WR_ADR_I,
  input  logic [XLEN-1:0]             WB_WR_DAT_I,
  output logic                        WB_WR_ACK_O,
  output logic                        timer_irq
);

  localparam logic [MM_REG_ADDR_BITS:0] BASE_W = (MM_REG_ADDR_BITS+1)'(BASE_ADDR);
  localparam logic [MM_REG_ADDR_BITS:0] LAST_W = BASE_W + (MM_REG_ADDR_BITS+1)'(7);

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [31:0]           hi_shadow;
  logic                  run;
  logic                  irq_en;
  logic [PRESCALE_W-1:0] prescale;
  logic                  cmp_hit;
  logic                  tick;

  // Handshake: a strobe on an in-range address is a complete request; the
  // block never stalls, so ACK is high for exactly the next cycle and read
  // data is non-zero only while ACK is high. Out-of-range strobes are ignored.
  logic [MM_REG_ADDR_BITS:0] rd_adr_ext, wr_adr_ext;
  logic                      rd_hit, wr_hit;
  logic [2:0]                rd_off, wr_off;

  assign rd_adr_ext = {1'b0, WB_RD_ADR_I};
  assign wr_adr_ext = {1'b0, WB_WR_ADR_I};
  assign rd_hit = WB_RD_STB_I && (rd_adr_ext >= BASE_W) && (rd_adr_ext <= LAST_W);
  assign wr_hit = WB_WR_STB_I && WB_WR_WE_I && (wr_adr_ext >= BASE_W) && (wr_adr_ext <= LAST_W);
  // Modulo-8 subtraction of the low bits is exact once the range check passed.
  assign rd_off = WB_RD_ADR_I[2:0] - BASE_W[2:0];
  assign wr_off = WB_WR_ADR_I[2:0] - BASE_W[2:0];

  logic [XLEN-1:0]       ctrl_word;
  logic                  ctrl_wr;
  logic                  run_next, irq_en_next;
  logic [PRESCALE_W-1:0] prescale_next;

  assign ctrl_word     = {run, irq_en, 14'b0, prescale};
  assign ctrl_wr       = wr_hit && (wr_off == OFF_CTRL);
  assign run_next      = WB_WR_SEL_I[3] ? WB_WR_DAT_I[CTRL_RUN_BIT]    : run;
  assign irq_en_next   = WB_WR_SEL_I[3] ? WB_WR_DAT_I[CTRL_IRQ_EN_BIT] : irq_en;
  assign prescale_next = {WB_WR_SEL_I[1] ? WB_WR_DAT_I[15:8] : prescale[15:8],
                          WB_WR_SEL_I[0] ? WB_WR_DAT_I[7:0]  : prescale[7:0]};

  timer_prescaler #(
    .PRESCALE_RESET(PRESCALE_RESET)
  ) u_prescaler (
    .clk       (clk),
    .reset_n   (reset_n),
    .sync_reset(sync_reset),
    .run       (run),
    .prescale  (prescale),
    .load      (ctrl_wr),
    .load_val  (prescale_next),
    .tick      (tick)
  );

  logic [XLEN-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (rd_off)
      OFF_MTIME_LO:    rd_mux = mtime[31:0];
      OFF_MTIME_HI:    rd_mux = hi_shadow;
      OFF_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      OFF_CTRL:        rd_mux = ctrl_word;
      OFF_STATUS:      rd_mux = {{(XLEN-1){1'b0}}, cmp_hit};
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      WB_RD_ACK_O <= 1'b0;
      WB_RD_DAT_O <= '0;
      WB_WR_ACK_O <= 1'b0;
      hi_shadow   <= '0;
    end else if (sync_reset) begin
      WB_RD_ACK_O <= 1'b0;
      WB_RD_DAT_O <= '0;
      WB_WR_ACK_O <= 1'b0;
      hi_shadow   <= '0;
    end else begin
      WB_RD_ACK_O <= rd_hit;
      WB_RD_DAT_O <= rd_hit ? rd_mux : '0;
      WB_WR_ACK_O <= wr_hit;
      if (rd_hit && (rd_off == OFF_MTIME_LO)) hi_shadow <= mtime[63:32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= PRESCALE_RESET;
      mtimecmp <= '1;
    end else if (sync_reset) begin
      run      <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= PRESCALE_RESET;
      mtimecmp <= '1;
    end else if (wr_hit) begin
      if (wr_off == OFF_CTRL) begin
        run      <= run_next;
        irq_en   <= irq_en_next;
        prescale <= prescale_next;
      end
      if (wr_off == OFF_MTIMECMP_LO)
        mtimecmp[31:0] <= apply_sel(mtimecmp[31:0], WB_WR_DAT_I, WB_WR_SEL_I);
      if (wr_off == OFF_MTIMECMP_HI)
        mtimecmp[63:32] <= apply_sel(mtimecmp[63:32], WB_WR_DAT_I, WB_WR_SEL_I);
    end
  end

  // A software write to either mtime half wins over a coincident tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mtime <= '0;
    end else if (sync_reset) begin
      mtime <= '0;
    end else if (wr_hit && (wr_off == OFF_MTIME_LO)) begin
      mtime[31:0] <= apply_sel(mtime[31:0], WB_WR_DAT_I, WB_WR_SEL_I);
    end else if (wr_hit && (wr_off == OFF_MTIME_HI)) begin
      mtime[63:32] <= apply_sel(mtime[63:32], WB_WR_DAT_I, WB_WR_SEL_I);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_hit   <= 1'b0;
      timer_irq <= 1'b0;
    end else if (sync_reset) begin
      cmp_hit   <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      cmp_hit   <= (mtime >= mtimecmp);
      timer_irq <= cmp_hit && irq_en;
    end
  end

endmodule

// File: tb/tb_wb_machine_timer.sv
// Directed bench for wb_machine_timer: register reads go through an expected
// queue, writes and interrupt timing are checked inline.
module tb_wb_machine_timer;
  import wb_machine_timer_pkg::*;

  localparam int unsigned BASE = 16;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        sync_reset;
  logic                        rd_stb;
  logic [MM_REG_ADDR_BITS-1:0] rd_adr;
  logic [XLEN-1:0]             rd_dat;
  logic                        rd_ack;
  logic                        wr_stb;
  logic                        wr_we;
  logic [XLEN_BYTES-1:0]       wr_sel;
  logic [MM_REG_ADDR_BITS-1:0] wr_adr;
  logic [XLEN-1:0]             wr_dat;
  logic                        wr_ack;
  logic                        timer_irq;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  wb_machine_timer #(
    .BASE_ADDR     (BASE),
    .PRESCALE_RESET(16'd0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .WB_RD_STB_I(rd_stb),
    .WB_RD_ADR_I(rd_adr),
    .WB_RD_DAT_O(rd_dat),
    .WB_RD_ACK_O(rd_ack),
    .WB_WR_STB_I(wr_stb),
    .WB_WR_WE_I (wr_we),
    .WB_WR_SEL_I(wr_sel),
    .WB_WR_ADR_I(wr_adr),
    .WB_WR_DAT_I(wr_dat),
    .WB_WR_ACK_O(wr_ack),
    .timer_irq  (timer_irq)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_sync_reset();
    @(negedge clk);
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
  endtask

  // Read an in-range offset; the expected value is queued at drive time and
  // popped when the acknowledge is observed.
  task automatic rd_exp(input int off, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    rd_stb = 1'b1;
    rd_adr = MM_REG_ADDR_BITS'(BASE + off);
    @(posedge clk);
    #1;
    rd_stb = 1'b0;
    check({tag, " ack"}, {31'b0, rd_ack}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty got=%h exp=queued", tag, rd_dat);
    end else begin
      e = exp_q.pop_front();
      check(tag, rd_dat, e);
    end
  endtask

  task automatic rd_get(input int off, output logic [31:0] val);
    @(negedge clk);
    rd_stb = 1'b1;
    rd_adr = MM_REG_ADDR_BITS'(BASE + off);
    @(posedge clk);
    #1;
    rd_stb = 1'b0;
    check("rd_get ack", {31'b0, rd_ack}, 32'd1);
    val = rd_dat;
  endtask

  task automatic rd_miss(input int adr, input string tag);
    @(negedge clk);
    rd_stb = 1'b1;
    rd_adr = MM_REG_ADDR_BITS'(adr);
    @(posedge clk);
    #1;
    rd_stb = 1'b0;
    check({tag, " ack"}, {31'b0, rd_ack}, 32'd0);
    check({tag, " dat"}, rd_dat, 32'd0);
  endtask

  task automatic wr(input int adr, input logic [31:0] dat, input logic [3:0] sel,
                    input logic we, input logic exp_ack, input string tag);
    @(negedge clk);
    wr_stb = 1'b1;
    wr_we  = we;
    wr_adr = MM_REG_ADDR_BITS'(adr);
    wr_dat = dat;
    wr_sel = sel;
    @(posedge clk);
    #1;
    wr_stb = 1'b0;
    wr_we  = 1'b0;
    check({tag, " wack"}, {31'b0, wr_ack}, {31'b0, exp_ack});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] v;
    reset_n = 1'b0; sync_reset = 1'b0;
    rd_stb = 1'b0; rd_adr = '0;
    wr_stb = 1'b0; wr_we = 1'b0; wr_sel = '0; wr_adr = '0; wr_dat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state and single-cycle acks.
    check("reset rd_ack", {31'b0, rd_ack}, 32'd0);
    check("reset irq", {31'b0, timer_irq}, 32'd0);
    rd_exp(0, 32'h0, "rst mtime_lo");
    rd_exp(1, 32'h0, "rst mtime_hi");
    rd_exp(2, 32'hFFFF_FFFF, "rst cmp_lo");
    rd_exp(3, 32'hFFFF_FFFF, "rst cmp_hi");
    rd_exp(4, 32'h0, "rst ctrl");
    rd_exp(5, 32'h0, "rst status");
    rd_exp(6, 32'h0, "rst rsvd6");
    @(posedge clk);
    #1;
    check("ack one cycle", {31'b0, rd_ack}, 32'd0);
    check("dat zero idle", rd_dat, 32'd0);

    // Byte lanes, decode boundaries, WE gating, reserved words.
    wr(BASE + 2, 32'hAABB_CCDD, 4'b0010, 1'b1, 1'b1, "sel cmp_lo");
    rd_exp(2, 32'hFFFF_CCFF, "sel cmp_lo rd");
    wr(BASE + 8, 32'h1234_5678, 4'hF, 1'b1, 1'b0, "wr base+8");
    wr(BASE - 1, 32'h1234_5678, 4'hF, 1'b1, 1'b0, "wr base-1");
    wr(BASE + 3, 32'h0, 4'hF, 1'b0, 1'b0, "wr we0");
    rd_exp(2, 32'hFFFF_CCFF, "cmp_lo unchanged");
    rd_exp(3, 32'hFFFF_FFFF, "cmp_hi unchanged");
    rd_miss(BASE + 8, "rd base+8");
    rd_miss(BASE - 1, "rd base-1");
    wr(BASE + 7, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, "wr rsvd7");
    rd_exp(7, 32'h0, "rsvd7 rd");

    // Prescale 3: one tick every four cycles.
    do_sync_reset();
    wr(BASE + 4, 32'h8000_0003, 4'hF, 1'b1, 1'b1, "ctrl ps3");
    rd_exp(4, 32'h8000_0003, "ctrl ps3 rd");
    repeat (40) @(posedge clk);
    rd_get(0, v);
    check("ps3 mtime window", {31'b0, (v >= 32'd9 && v <= 32'd11)}, 32'd1);

    // Carry into HI and the shadowed HI read.
    do_sync_reset();
    wr(BASE + 0, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, "mtime_lo ff");
    wr(BASE + 1, 32'h0, 4'hF, 1'b1, 1'b1, "mtime_hi 0");
    wr(BASE + 4, 32'h8000_0000, 4'hF, 1'b1, 1'b1, "ctrl run");
    @(posedge clk);
    rd_exp(0, 32'h0, "carry lo");
    rd_exp(1, 32'h1, "carry hi");
    wr(BASE + 4, 32'h0, 4'hF, 1'b1, 1'b1, "ctrl stop");
    wr(BASE + 1, 32'h5, 4'hF, 1'b1, 1'b1, "mtime_hi 5");
    wr(BASE + 0, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, "mtime_lo ff2");
    wr(BASE + 4, 32'h8000_0000, 4'hF, 1'b1, 1'b1, "ctrl run2");
    rd_exp(0, 32'hFFFF_FFFF, "shadow lo");
    rd_exp(1, 32'h5, "shadow hi held");
    rd_exp(0, 32'h1, "shadow lo2");
    rd_exp(1, 32'h6, "shadow hi2");

    // Write coinciding with a tick wins.
    do_sync_reset();
    wr(BASE + 4, 32'h8000_0000, 4'hF, 1'b1, 1'b1, "ctrl run3");
    wr(BASE + 0, 32'h0000_0100, 4'hF, 1'b1, 1'b1, "mtime_lo 100");
    rd_exp(0, 32'h0000_0100, "tick vs write");

    // Compare and interrupt latency.
    do_sync_reset();
    wr(BASE + 2, 32'd20, 4'hF, 1'b1, 1'b1, "cmp_lo 20");
    wr(BASE + 3, 32'd0, 4'hF, 1'b1, 1'b1, "cmp_hi 0");
    wr(BASE + 4, 32'hC000_0000, 4'hF, 1'b1, 1'b1, "ctrl run irq");
    check("irq low early", {31'b0, timer_irq}, 32'd0);
    repeat (21) @(posedge clk);
    #1;
    check("irq low at hit", {31'b0, timer_irq}, 32'd0);
    @(posedge clk);
    #1;
    check("irq rise", {31'b0, timer_irq}, 32'd1);
    rd_exp(5, 32'h1, "status hit");
    wr(BASE + 3, 32'd1, 4'hF, 1'b1, 1'b1, "cmp_hi 1");
    check("irq hold 0", {31'b0, timer_irq}, 32'd1);
    @(posedge clk);
    #1;
    check("irq hold 1", {31'b0, timer_irq}, 32'd1);
    @(posedge clk);
    #1;
    check("irq fall", {31'b0, timer_irq}, 32'd0);
    rd_exp(5, 32'h0, "status clear");

    // Read and write ports acknowledging in the same cycle.
    fork
      rd_exp(4, 32'hC000_0000, "par ctrl rd");
      wr(BASE + 2, 32'h0000_00AA, 4'b0001, 1'b1, 1'b1, "par cmp_lo wr");
    join
    rd_exp(2, 32'h0000_00AA, "par cmp_lo rd");

    // Async reset while a read ack is outstanding.
    wr(BASE + 4, 32'h8000_0005, 4'hF, 1'b1, 1'b1, "ctrl pre-rst");
    @(negedge clk);
    rd_stb = 1'b1;
    rd_adr = MM_REG_ADDR_BITS'(BASE + 2);
    @(posedge clk);
    #1;
    rd_stb = 1'b0;
    check("pend ack", {31'b0, rd_ack}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst drops ack", {31'b0, rd_ack}, 32'd0);
    check("rst drops dat", rd_dat, 32'd0);
    @(posedge clk);
    #1;
    check("no reissue", {31'b0, rd_ack}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("post rst irq", {31'b0, timer_irq}, 32'd0);
    rd_exp(0, 32'h0, "post rst mtime_lo");
    rd_exp(1, 32'h0, "post rst mtime_hi");
    rd_exp(2, 32'hFFFF_FFFF, "post rst cmp_lo");
    rd_exp(3, 32'hFFFF_FFFF, "post rst cmp_hi");
    rd_exp(4, 32'h0, "post rst ctrl");
    rd_exp(5, 32'h0, "post rst status");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
